// File: rtl/serial_add_unit.sv
`default_nettype none
// ============================================================================
//  Module      : serial_add_unit (with full_adder cell)
//  Description : Bit-serial add/subtract engine. Latches two WIDTH-bit
//                operands and streams them LSB-first through a single
//                full-adder cell, one bit per clock, with the carry fed
//                back through a flop. Result, carry-out and signed
//                overflow are registered when the last bit completes.
//  Revision    : 1.0  initial release
// ============================================================================

// Single-bit full adder; carry built from the classic NAND-NAND form.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic w_axb;

    assign w_axb = a ^ b;
    assign s     = w_axb ^ ci;
    assign co    = ~(~(a & b) & ~(ci & w_axb));
endmodule

module serial_add_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int c_cnt_w = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_shift = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;

    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_res_sh;
    logic               r_c;
    logic               r_sub_q;
    logic [c_cnt_w-1:0] r_cnt;

    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;

    logic               w_fa_a;
    logic               w_fa_b;
    logic               w_fa_s;
    logic               w_fa_co;
    logic               w_last;

    // Subtraction inverts B and seeds the carry with 1 (A + ~B + 1).
    assign w_fa_a = r_a_sh[0];
    assign w_fa_b = r_b_sh[0] ^ r_sub_q;
    assign w_last = (r_cnt == c_last);

    full_adder u_fa (
        .a  (w_fa_a),
        .b  (w_fa_b),
        .ci (r_c),
        .s  (w_fa_s),
        .co (w_fa_co)
    );

    // Next-state decode: IDLE -> SHIFT on start, SHIFT -> DONE after last bit.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle:  if (start) w_next_state = c_st_shift;
            c_st_shift: if (w_last) w_next_state = c_st_done;
            c_st_done:  w_next_state = c_st_idle;
            default:    w_next_state = c_st_idle;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Operand load, bit-serial shifting and final result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res_sh <= '0;
            r_c      <= 1'b0;
            r_sub_q  <= 1'b0;
            r_cnt    <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_sub_q <= sub;
                        r_c     <= sub;
                        r_cnt   <= '0;
                    end
                end
                c_st_shift: begin
                    r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_res_sh <= {w_fa_s, r_res_sh[WIDTH-1:1]};
                    r_c      <= w_fa_co;
                    r_cnt    <= r_cnt + c_cnt_w'(1);
                    if (w_last) begin
                        // Carry into the MSB is still in r_c on this cycle.
                        r_sum  <= {w_fa_s, r_res_sh[WIDTH-1:1]};
                        r_cout <= w_fa_co;
                        r_ovf  <= w_fa_co ^ r_c;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (r_state == c_st_shift);
    assign done = (r_state == c_st_done);
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_serial_add_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_add_unit
//  Description : Self-checking bench for serial_add_unit (WIDTH=8):
//                directed vector table, ignored-start and reset sequences,
//                and a seeded random sweep against an arithmetic model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_add_unit;
    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int total;
    int bad;

    typedef struct {
        logic       sub;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t vecs[10];

    serial_add_unit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    // 20 ns clock.
    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Reference: {ovf, cout, sum} from a 9-bit add of a and (possibly inverted) b.
    function automatic logic [9:0] model(input logic s, input logic [7:0] x, input logic [7:0] y);
        logic [7:0] bb;
        logic [8:0] t;
        logic       v;
        bb = s ? ~y : y;
        t  = {1'b0, x} + {1'b0, bb} + {8'b0, s};
        v  = (x[7] == bb[7]) && (t[7] != x[7]);
        return {v, t[8], t[7:0]};
    endfunction

    // Run one operation from IDLE; returns to IDLE before exiting.
    task automatic do_op(input logic s, input logic [7:0] x, input logic [7:0] y, input bit timing);
        logic [7:0] prev;
        int         lat;
        int         bc;
        bit         held;
        prev  = sum;
        held  = 1'b1;
        sub   = s;
        a     = x;
        b     = y;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = '0;
        b     = '0;
        sub   = 1'b0;
        lat   = 0;
        bc    = 0;
        while (!done && lat < 40) begin
            if (busy) bc++;
            if (sum !== prev) held = 1'b0;
            tick();
            lat++;
        end
        chk("done_seen", {31'b0, done}, 32'd1);
        if (timing) begin
            chk("latency", lat, WIDTH);
            chk("busy_cycles", bc, WIDTH);
            chk("sum_held_during_shift", {31'b0, held}, 32'd1);
            chk("busy_in_done", {31'b0, busy}, 32'd0);
        end
        tick();
        if (timing) chk("done_one_cycle", {31'b0, done}, 32'd0);
    endtask

    initial begin
        int   n;
        int   pulses;
        int   busies;
        logic s;
        logic [7:0] x;
        logic [7:0] y;
        logic [9:0] m;

        total = 0;
        bad   = 0;

        vecs[0] = '{1'b0, 8'h35, 8'h4A, 8'h7F, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
        vecs[6] = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 8'h7F, 8'hFF, 8'h80, 1'b0, 1'b1};
        vecs[8] = '{1'b0, 8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b0};
        vecs[9] = '{1'b0, 8'hC8, 8'h9C, 8'h64, 1'b1, 1'b1};

        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_sum",  {24'b0, sum},  32'd0);
        chk("rst_cout", {31'b0, cout}, 32'd0);
        chk("rst_ovf",  {31'b0, ovf},  32'd0);

        // Directed vector table.
        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].sub, vecs[i].a, vecs[i].b, 1'b1);
            chk("vec_sum",  {24'b0, sum},  {24'b0, vecs[i].sum});
            chk("vec_cout", {31'b0, cout}, {31'b0, vecs[i].cout});
            chk("vec_ovf",  {31'b0, ovf},  {31'b0, vecs[i].ovf});
        end

        // start during SHIFT and during DONE must be ignored.
        sub   = 1'b0;
        a     = 8'h01;
        b     = 8'h01;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        a     = 8'hAA;
        b     = 8'h55;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 3;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        chk("ign_latency", n, WIDTH);
        chk("ign_sum_at_done", {24'b0, sum}, 32'h02);
        a     = 8'hAA;
        b     = 8'h55;
        start = 1'b1;
        tick();
        start  = 1'b0;
        pulses = 0;
        busies = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) pulses++;
            if (busy) busies++;
            tick();
        end
        chk("ign_extra_done", pulses, 0);
        chk("ign_extra_busy", busies, 0);
        chk("ign_sum_kept", {24'b0, sum}, 32'h02);
        do_op(1'b0, 8'hAA, 8'h55, 1'b1);
        chk("after_ign_sum", {24'b0, sum}, 32'hFF);

        // Reset in the middle of an operation; first make all outputs nonzero.
        do_op(1'b0, 8'hC8, 8'h9C, 1'b0);
        sub   = 1'b0;
        a     = 8'h12;
        b     = 8'h34;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_done", {31'b0, done}, 32'd0);
        chk("midrst_sum",  {24'b0, sum},  32'd0);
        chk("midrst_cout", {31'b0, cout}, 32'd0);
        chk("midrst_ovf",  {31'b0, ovf},  32'd0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) pulses++;
            tick();
        end
        chk("midrst_no_done", pulses, 0);
        do_op(1'b0, 8'h0F, 8'h01, 1'b1);
        chk("after_rst_sum", {24'b0, sum}, 32'h10);

        // Reset wins over start on the same edge.
        rst   = 1'b1;
        start = 1'b1;
        a     = 8'h11;
        b     = 8'h22;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        chk("rst_start_busy", {31'b0, busy}, 32'd0);
        pulses = 0;
        busies = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) pulses++;
            if (busy) busies++;
            tick();
        end
        chk("rst_start_no_done", pulses, 0);
        chk("rst_start_no_busy", busies, 0);

        // Random sweep against the arithmetic model.
        for (int i = 0; i < 1000; i++) begin
            s = 1'($urandom_range(1, 0));
            x = 8'($urandom_range(255, 0));
            y = 8'($urandom_range(255, 0));
            m = model(s, x, y);
            do_op(s, x, y, 1'b0);
            chk("rnd_sum",  {24'b0, sum},  {24'b0, m[7:0]});
            chk("rnd_cout", {31'b0, cout}, {31'b0, m[8]});
            chk("rnd_ovf",  {31'b0, ovf},  {31'b0, m[9]});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/serial_add_unit.md
# serial_add_unit

Bit-serial add/subtract engine built around a single `Full_Adder` cell. It latches two WIDTH-bit operands and feeds them LSB-first into the cell, one bit per clock. Each sum bit is shifted into a result register, and carry-out is registered and fed back as the next carry-in. It sits between the register-file read ports and the ALU result bus, acting as the low-area add/sub path. It both feeds the full-adder cell and consumes its outputs.

## Interface
- `WIDTH`, default 8: operand/result width in bits (≥2).
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request to begin an operation; sampled only in IDLE.
- `sub`  in  1  0 = A+B, 1 = A−B; latched with `start`.
- `a`  in  WIDTH  operand A; latched with `start`.
- `b`  in  WIDTH  operand B; latched with `start`.
- `busy`  out  1  high while an operation is in progress (SHIFT state).
- `done`  out  1  one-cycle pulse when the result registers are valid.
- `sum`  out  WIDTH  result, two's complement.
- `cout`  out  1  final carry-out. For sub, 1 = no borrow.
- `ovf`  out  1  signed overflow.

## Operation
- Datapath: operand shift regs `a_sh`, `b_sh`, a carry flop `c`, result shift reg `r_sh`, bit counter `cnt` (clog2(WIDTH+1) bits), latched `sub_q`.
- Per-bit cell inputs:
  - A = `a_sh[0]`.
  - B = `b_sh[0] ^ sub_q`.
  - Ci = `c`.
- Cell outputs S and Co drive the next-state logic only. They are never output directly.
- FSM states and transitions:
  - IDLE: `busy`=0. On `start`=1: `a_sh`←a, `b_sh`←b, `sub_q`←sub, `c`←sub, `cnt`←0, go to SHIFT.
  - SHIFT: `busy`=1. Each cycle:
    - `a_sh`, `b_sh` shift right by 1.
    - `r_sh` ← {S, `r_sh`[WIDTH-1:1]}.
    - `c`←Co.
    - `cnt`←`cnt`+1.
    - On the cycle where `cnt`==WIDTH-1:
      - `sum`←{S, `r_sh`[WIDTH-1:1]}.
      - `cout`←Co.
      - `ovf`←Co ^ `c` (carry into MSB xor carry out of MSB).
      - Go to DONE.
  - DONE: `done`=1 for exactly this cycle, `busy`=0. Unconditionally go to IDLE.
- `start` in SHIFT or DONE is ignored. It is not queued.
- `sum`, `cout`, `ovf` hold their value from the last completed operation until the next operation completes. They do not change during SHIFT.
- Arithmetic wraps modulo 2^WIDTH. Subtraction is A + ~B + 1.
- Reset (any state, including mid-SHIFT):
  - Next edge gives IDLE.
  - `busy`=0, `done`=0, `sum`=0, `cout`=0, `ovf`=0.
  - `a_sh`, `b_sh`, `r_sh`, `c`, `cnt`, `sub_q` all cleared.
  - The in-flight operation is discarded with no `done` pulse.
- Reset has priority over `start` on the same edge.

## Timing
- `start` is sampled at edge t (in IDLE).
  - `busy` is high from t+1 through t+WIDTH.
  - The outputs update and `done` is high during cycle t+WIDTH+1.
- Latency is WIDTH+1 cycles from the `start` edge to `done`. The earliest next accepted `start` is at edge t+WIDTH+2, so throughput is one operation per WIDTH+2 cycles.
- Clock period must exceed the cell's combinational path.
  - Worst case is XOR+XOR = 10 ns on S, and XOR+NAND+NAND on Co.
  - Simulate with a period ≥ 20 ns. The bench samples outputs on the rising edge only.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- WIDTH=8, `sub`=0, a=0x35, b=0x4A → `done` at t+9; `sum`=0x7F, `cout`=0, `ovf`=0; `busy` high for exactly 8 cycles.
- `sub`=0:
  - a=0x7F, b=0x01 → `sum`=0x80, `cout`=0, `ovf`=1.
  - a=0xFF, b=0x01 → `sum`=0x00, `cout`=1, `ovf`=0.
- `sub`=1:
  - a=0x10, b=0x20 → `sum`=0xF0, `cout`=0, `ovf`=0.
  - a=0x80, b=0x01 → `sum`=0x7F, `cout`=1, `ovf`=1.
- Start 0x01+0x01, then pulse `start` with 0xAA+0x55 at t+3 and at the DONE cycle → both ignored; only one `done`, with `sum`=0x02; the next start from IDLE gives `sum`=0xFF.
- Reset handling:
  - Assert `rst` at t+4 of an operation → no `done`; every output is 0 the cycle after reset; a fresh 0x0F+0x01 afterwards gives `sum`=0x10.
  - `rst` and `start` on the same edge → stays IDLE.
- Random sweep, 1000 operand pairs with random `sub` → `sum`, `cout`, `ovf` match the reference model computed from (a ± b) at WIDTH+1 bits.
